inst_mem: RTL and testbench

INST_MEM -- requirements
Module: inst_mem

---
 rtl/inst_mem.sv | 198 +++++++++++++++++++
 tb/tb_inst_mem.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem.sv
// ============================================================================
// inst_mem -- instruction memory with power-on clear sweep and program load
//
// After reset the memory walks addresses 0..DEPTH-1 and writes DEFAULT_INST
// to each one, one entry per cycle (CLEAR). It then enters READY. In READY it
// serves one fetch per cycle with a latency of one cycle and accepts one
// program-load write per cycle. A load and a fetch to the same address in the
// same cycle are read-first. Addresses at or above DEPTH fetch DEFAULT_INST,
// and loads to those addresses are dropped.
//
// Optional feature: define INST_MEM_PARITY_EN to store an even-parity bit per
// entry and flag mismatches on fetch. Without it, parity_err_o is tied to 0.
//
// Parameters
//   ADDR_W        address width in bits
//   INST_W        instruction width in bits
//   DEPTH         number of stored instructions (1 .. 2**ADDR_W)
//   DEFAULT_INST  clear value, also returned for out-of-range fetches
//
// Ports
//   clk            sole clock, rising edge
//   reset          synchronous, active-high reset
//   fetch_req_i    fetch request
//   fetch_addr_i   fetch address
//   instruction_o  fetched instruction (holds when no fetch result)
//   inst_valid_o   instruction_o carries a fetch result this cycle
//   load_we_i      program-load write strobe
//   load_addr_i    program-load address
//   load_data_i    program-load data
//   busy_o         clear sweep in progress; fetch and load are ignored
//   parity_err_o   parity mismatch on the current fetch result
// ============================================================================
module inst_mem #(
    parameter int                ADDR_W       = 8,
    parameter int                INST_W       = 8,
    parameter int                DEPTH        = 256,
    parameter logic [INST_W-1:0] DEFAULT_INST = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic [INST_W-1:0] instruction_o,
    output logic              inst_valid_o,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [INST_W-1:0] load_data_i,
    output logic              busy_o,
    output logic              parity_err_o
);

    // Only the low IDX_W address bits select an entry; range checks against
    // the full address stop aliasing of addresses >= DEPTH.
    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;

    logic [INST_W-1:0]   mem_q [DEPTH];

    logic                fetch_in_range;
    logic                load_in_range;
    logic                fetch_accept;
    logic [INST_W-1:0]   rd_data;
    logic                rd_perr;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [INST_W-1:0]   wr_data;

    assign fetch_in_range = ({1'b0, fetch_addr_i} < DEPTH_L);
    assign load_in_range  = ({1'b0, load_addr_i} < DEPTH_L);
    assign fetch_accept   = (state_q == ST_READY) && fetch_req_i;

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; this is also what makes a same-cycle
    // load/fetch read the old contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Control FSM: next state and memory write-port selection
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_en     = 1'b0;
        wr_idx    = load_addr_i[IDX_W-1:0];
        wr_data   = load_data_i;
        unique case (state_q)
            ST_CLEAR: begin
                wr_en   = !reset;
                wr_idx  = clr_ptr_q[IDX_W-1:0];
                wr_data = DEFAULT_INST;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d   = ST_READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            ST_READY: begin
                wr_en = !reset && load_we_i && load_in_range;
            end
            default: ;
        endcase
    end

    assign busy_o = (state_q == ST_CLEAR);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // NOTE: the array has no reset; its contents are defined solely by the
    // clear sweep, which keeps it mappable onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

`ifdef INST_MEM_PARITY_EN
    logic par_q [DEPTH];

    // Even parity: the stored bit makes the total count of ones even.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_q[wr_idx] <= ^wr_data;
        end
    end

    always_comb begin
        rd_data = DEFAULT_INST;
        rd_perr = 1'b0;
        if (fetch_in_range) begin
            rd_data = mem_q[fetch_addr_i[IDX_W-1:0]];
            rd_perr = (^rd_data) ^ par_q[fetch_addr_i[IDX_W-1:0]];
        end
    end
`else
    always_comb begin
        rd_data = DEFAULT_INST;
        rd_perr = 1'b0;
        if (fetch_in_range) begin
            rd_data = mem_q[fetch_addr_i[IDX_W-1:0]];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Fetch result register: instruction holds when no fetch is accepted
    // ------------------------------------------------------------------
    always_comb begin
        inst_d  = inst_q;
        valid_d = fetch_accept;
        perr_d  = 1'b0;
        if (fetch_accept) begin
            inst_d = rd_data;
            perr_d = rd_perr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_q  <= DEFAULT_INST;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
        end
    end

    assign instruction_o = inst_q;
    assign inst_valid_o  = valid_q;
    assign parity_err_o  = perr_q;

endmodule

// File: tb/tb_inst_mem.sv
// ============================================================================
// tb_inst_mem -- bench for inst_mem
//
// Two instances share one stimulus stream: dut0 with DEPTH=256 and dut1 with
// DEPTH=64, so out-of-range behaviour is exercised alongside the full-size
// memory. A behavioural model (array + clear-cycle countdown) predicts all
// outputs of both instances and is compared on every falling edge; literal
// expectations at key points pin the model itself.
// With INST_MEM_PARITY_EN defined, a stored bit of dut0 is flipped to
// exercise the parity check.
// ============================================================================
module tb_inst_mem;

    localparam int NDUT = 2;
    localparam int DEPTHS [NDUT] = '{256, 64};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fetch_req = 1'b0;
    logic [7:0] fetch_addr = '0;
    logic       load_we = 1'b0;
    logic [7:0] load_addr = '0;
    logic [7:0] load_data = '0;

    logic [7:0] inst   [NDUT];
    logic       valid  [NDUT];
    logic       busy   [NDUT];
    logic       perr   [NDUT];

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    inst_mem #(.ADDR_W(8), .INST_W(8), .DEPTH(256), .DEFAULT_INST(8'hFF)) dut0 (
        .clk(clk), .reset(reset),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
        .instruction_o(inst[0]), .inst_valid_o(valid[0]),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
        .busy_o(busy[0]), .parity_err_o(perr[0])
    );

    inst_mem #(.ADDR_W(8), .INST_W(8), .DEPTH(64), .DEFAULT_INST(8'hFF)) dut1 (
        .clk(clk), .reset(reset),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr),
        .instruction_o(inst[1]), .inst_valid_o(valid[1]),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
        .busy_o(busy[1]), .parity_err_o(perr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: memory image, remaining clear cycles, expected outputs
    // ------------------------------------------------------------------
    logic [7:0] m_mem  [NDUT][256];
    bit         m_bad  [NDUT][256];
    int         m_left [NDUT];
    logic [7:0] e_inst [NDUT];
    logic       e_valid[NDUT];
    logic       e_busy [NDUT];
    logic       e_perr [NDUT];

    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            if (reset) begin
                m_left[k]  = DEPTHS[k];
                e_busy[k]  = 1'b1;
                e_valid[k] = 1'b0;
                e_inst[k]  = 8'hFF;
                e_perr[k]  = 1'b0;
                for (int i = 0; i < 256; i++) begin
                    m_mem[k][i] = 8'hFF;
                    m_bad[k][i] = 1'b0;
                end
            end else if (m_left[k] > 0) begin
                m_left[k]  = m_left[k] - 1;
                e_busy[k]  = (m_left[k] != 0);
                e_valid[k] = 1'b0;
                e_perr[k]  = 1'b0;
            end else begin
                e_busy[k]  = 1'b0;
                e_valid[k] = fetch_req;
                e_perr[k]  = 1'b0;
                if (fetch_req) begin
                    if (int'(fetch_addr) < DEPTHS[k]) begin
                        e_inst[k] = m_mem[k][fetch_addr];
                        e_perr[k] = m_bad[k][fetch_addr];
                    end else begin
                        e_inst[k] = 8'hFF;
                    end
                end
                if (load_we && int'(load_addr) < DEPTHS[k]) begin
                    m_mem[k][load_addr] = load_data;
                    m_bad[k][load_addr] = 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < NDUT; k++) begin
                check($sformatf("busy%0d", k),  32'(busy[k]),  32'(e_busy[k]));
                check($sformatf("valid%0d", k), 32'(valid[k]), 32'(e_valid[k]));
                check($sformatf("inst%0d", k),  32'(inst[k]),  32'(e_inst[k]));
                check($sformatf("perr%0d", k),  32'(perr[k]),  32'(e_perr[k]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input logic f, input logic [7:0] fa,
                        input logic l, input logic [7:0] la, input logic [7:0] ld);
        fetch_req  = f;
        fetch_addr = fa;
        load_we    = l;
        load_addr  = la;
        load_data  = ld;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic fetch(input logic [7:0] a);
        tick(1'b1, a, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        tick(1'b0, 8'h00, 1'b1, a, d);
    endtask

    // Counts dut0 busy cycles with fetch requests applied throughout
    task automatic count_busy(input logic [7:0] fa, output int n);
        n = 0;
        while (busy[0] && n < 300) begin
            tick(1'b1, fa, 1'b0, 8'h00, 8'h00);
            n++;
        end
    endtask

    int n_busy;

    initial begin
        // Reset for one cycle
        reset = 1'b1;
        idle();
        check_en = 1'b1;
        check("rst_busy", 32'(busy[0]), 32'd1);
        check("rst_valid", 32'(valid[0]), 32'd0);
        check("rst_inst", 32'(inst[0]), 32'hFF);
        check("rst_perr", 32'(perr[0]), 32'd0);
        reset = 1'b0;

        // Clear sweep: busy for exactly DEPTH cycles, fetches ignored
        count_busy(8'h10, n_busy);
        check("busy_cycles", 32'(n_busy), 32'd256);
        check("busy_done", 32'(busy[0]), 32'd0);
        check("valid_in_busy", 32'(valid[0]), 32'd0);

        fetch(8'h10);
        check("fetch10_inst", 32'(inst[0]), 32'hFF);
        check("fetch10_valid", 32'(valid[0]), 32'd1);

        // Loads then back-to-back fetches
        load(8'h00, 8'hC0);
        load(8'h03, 8'h11);
        fetch(8'h03);
        check("b2b_first", 32'(inst[0]), 32'h11);
        fetch(8'h00);
        check("b2b_second", 32'(inst[0]), 32'hC0);
        check("b2b_valid", 32'(valid[0]), 32'd1);

        // Same-cycle load and fetch: read-first
        tick(1'b1, 8'h05, 1'b1, 8'h05, 8'h42);
        check("rdfirst_old", 32'(inst[0]), 32'hFF);
        fetch(8'h05);
        check("rdfirst_new", 32'(inst[0]), 32'h42);

        // No fetch: valid drops, instruction holds
        idle();
        check("hold_valid", 32'(valid[0]), 32'd0);
        check("hold_inst", 32'(inst[0]), 32'h42);

        // Out-of-range for the DEPTH=64 instance
        fetch(8'h80);
        check("oor_inst64", 32'(inst[1]), 32'hFF);
        check("oor_valid64", 32'(valid[1]), 32'd1);
        load(8'h80, 8'hAA);
        load(8'hC3, 8'h5A);
        fetch(8'h80);
        check("oor_load256", 32'(inst[0]), 32'hAA);
        check("oor_load64", 32'(inst[1]), 32'hFF);
        fetch(8'h00);
        check("no_alias0_64", 32'(inst[1]), 32'hC0);
        fetch(8'h03);
        check("no_alias3_64", 32'(inst[1]), 32'h11);
        fetch(8'h3F);
        check("last_entry64", 32'(inst[1]), 32'hFF);

        // A run of varied loads and fetches, model-checked each cycle
        for (int i = 0; i < 16; i++) begin
            tick(1'(i % 3 != 0), 8'((i * 37) & 8'h7F),
                 1'(i % 2 == 0), 8'((i * 53) & 8'hFF), 8'(i * 11 + 1));
        end
        idle();

        // Reset pulse mid-READY: sweep restarts, loads are lost
        reset = 1'b1;
        idle();
        reset = 1'b0;
        count_busy(8'h00, n_busy);
        check("rst2_busy_cycles", 32'(n_busy), 32'd256);
        fetch(8'h00);
        check("rst2_addr0", 32'(inst[0]), 32'hFF);
        fetch(8'h03);
        check("rst2_addr3", 32'(inst[0]), 32'hFF);
        fetch(8'h05);
        check("rst2_addr5", 32'(inst[0]), 32'hFF);
        check("rst2_valid", 32'(valid[0]), 32'd1);

`ifdef INST_MEM_PARITY_EN
        // Flip one stored bit at 0x07 behind the parity bit
        dut0.mem_q[7] = dut0.mem_q[7] ^ 8'h01;
        m_mem[0][7]   = m_mem[0][7] ^ 8'h01;
        m_bad[0][7]   = 1'b1;
        fetch(8'h07);
        check("par_err", 32'(perr[0]), 32'd1);
        check("par_valid", 32'(valid[0]), 32'd1);
        fetch(8'h06);
        check("par_clean", 32'(perr[0]), 32'd0);
        load(8'h07, 8'h33);
        fetch(8'h07);
        check("par_reload", 32'(perr[0]), 32'd0);
        check("par_reload_inst", 32'(inst[0]), 32'h33);
`endif

        idle();
        idle();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
